// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main control FSM and the datapath/alucont side.
// master = control unit (drives the selects and enables), slave = datapath (drives opcode and handshakes).
interface multicycle_control_if;
    logic [5:0] op;
    logic       jmorsig;
    logic       memready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic       zeroext;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [2:0] aluop;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, jmorsig, memready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, zeroext,
               alusrcb, pcsource, aluop, state, illegal
    );

    modport slave (
        output op, jmorsig, memready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, zeroext,
               alusrcb, pcsource, aluop, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor: sequences fetch/decode/execute/memory/writeback
// and decodes datapath selects, write enables and the ALU op from the current state.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ANDI  = 6'b001100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_JEX     = 4'd9;
    localparam logic [3:0] S_ANDIEX  = 4'd10;
    localparam logic [3:0] S_ANDIWB  = 4'd11;
    localparam logic [3:0] S_JMORJ   = 4'd12;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dec_state;
    logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite, w_irwrite;
    logic       w_memtoreg, w_regdst, w_regwrite, w_alusrca, w_zeroext, w_illegal;
    logic [1:0] w_alusrcb, w_pcsource;
    logic [2:0] w_aluop;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = bus.memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ANDI:      w_next = S_ANDIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      w_next = S_MEMRD;
                else if (bus.op == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:   w_next = bus.memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = bus.memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = bus.jmorsig ? S_JMORJ : S_RTYPEWB;
            S_ANDIEX:  w_next = S_ANDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // During reset the outputs decode as FETCH, then the write enables are masked off below.
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_zeroext     = 1'b0;
        w_illegal     = 1'b0;
        w_alusrcb     = 2'b00;
        w_pcsource    = 2'b00;
        w_aluop       = 3'b000;
        case (w_dec_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = bus.memready;
                w_pcwrite = bus.memready;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                w_illegal = !(bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_RTYPE ||
                              bus.op == OP_BEQ || bus.op == OP_J || bus.op == OP_ANDI);
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_iord    = 1'b1;
                w_memread = 1'b1;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 3'b010;
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_JMORJ: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b01;
            end
            S_BEQEX: begin
                w_alusrca     = 1'b1;
                w_aluop       = 3'b001;
                w_pcwritecond = 1'b1;
                w_pcsource    = 2'b01;
            end
            S_JEX: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
            end
            S_ANDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_zeroext = 1'b1;
                w_aluop   = 3'b100;
            end
            S_ANDIWB: w_regwrite = 1'b1;
            default: ;
        endcase
        if (reset) begin
            w_pcwrite     = 1'b0;
            w_pcwritecond = 1'b0;
            w_irwrite     = 1'b0;
            w_regwrite    = 1'b0;
            w_memwrite    = 1'b0;
            w_illegal     = 1'b0;
        end
    end

    assign bus.pcwrite     = w_pcwrite;
    assign bus.pcwritecond = w_pcwritecond;
    assign bus.iord        = w_iord;
    assign bus.memread     = w_memread;
    assign bus.memwrite    = w_memwrite;
    assign bus.irwrite     = w_irwrite;
    assign bus.memtoreg    = w_memtoreg;
    assign bus.regdst      = w_regdst;
    assign bus.regwrite    = w_regwrite;
    assign bus.alusrca     = w_alusrca;
    assign bus.zeroext     = w_zeroext;
    assign bus.alusrcb     = w_alusrcb;
    assign bus.pcsource    = w_pcsource;
    assign bus.aluop       = w_aluop;
    assign bus.illegal     = w_illegal;
    assign bus.state       = r_state;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle version of the processor.
- Sequences fetch, decode, execute, memory and writeback over several clocks per instruction, and drives the datapath mux selects and write enables.
- Drives the 3-bit ALU op into alucont.
- Takes back alucont's jmor flag to divert jmor out of the normal R-type writeback.
- Stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ANDI, 6'b001100, and-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instruction register opcode field
- jmorsig  in  1  from alucont; 1 = current R-type is jmor
- memready  in  1  memory has completed the current read/write this cycle
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, zeroext  out  1 each  datapath controls
- alusrcb  out  2  00 reg B, 01 const 4, 10 imm, 11 imm<<2
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  3  {aluop2,aluop1,aluop0} to alucont: 000 add, 001 sub, 010 R-type, 100 and
- state  out  4  current state encoding, for debug and verification
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- State register is 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9, ANDIEX=10, ANDIWB=11, JMORJ=12.
- Codes 13-15 go to FETCH on the next edge and assert no controls.
- Reset:
  - state <= FETCH on any edge with reset=1; this also applies mid-instruction.
  - While reset=1, pcwrite, pcwritecond, irwrite, regwrite, memwrite and illegal are forced to 0.
  - All other outputs take their FETCH values.
- Outputs are decoded combinationally from state, plus memready where noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsource=00.
  - irwrite=pcwrite=memready.
  - Stays in FETCH while memready=0; goes to DECODE when memready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut).
  - Next state by op: LW/SW -> MEMADR, RTYPE -> RTYPEEX, BEQ -> BEQEX, J -> JEX, ANDI -> ANDIEX.
  - Any other op: illegal=1 for this cycle, then -> FETCH.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=000.
  - LW -> MEMRD, SW -> MEMWR.
  - op is sampled here; the IR is stable because irwrite=0.
- MEMRD:
  - Outputs: iord=1, memread=1.
  - Holds until memready=1, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1.
  - memwrite stays high for every wait cycle; -> FETCH when memready=1.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=010.
  - jmorsig=1 -> JMORJ, else -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
- JMORJ: pcwrite=1, pcsource=01 (PC <= ALUOut), regwrite=0; -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=001, pcwritecond=1, pcsource=01; -> FETCH.
- JEX: pcwrite=1, pcsource=10; -> FETCH.
- ANDIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=100; -> ANDIWB.
- ANDIWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
- Latency in clocks, with memready=1 throughout:
  - LW 5; SW 4; R-type 4; jmor 4; ANDI 4; BEQ 3; J 3; illegal 2.
  - Each extra memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 clock.
- memready is ignored in every state other than FETCH, MEMRD and MEMWR.
- regwrite and memwrite are never asserted in the same cycle.

Test Plan:
- reset=1 for 2 cycles mid-MEMWR, then released -> state=0; memwrite=0 during reset; first post-reset cycle is FETCH with memread=1.
- LW, memready=1 always -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
- SW, memready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0.
- R-type with jmorsig=0 -> aluop=010 in state 6 and regdst=1/regwrite=1 in state 7. Same op with jmorsig=1 -> state 12, pcwrite=1, pcsource=01, regwrite never 1.
- BEQ -> aluop=001, pcwritecond=1 in state 8. J -> pcsource=10, pcwrite=1 in state 9. ANDI -> zeroext=1, aluop=100, then regwrite in state 11.
- op=6'b111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH with no write enable asserted. FETCH with memready=0 for 2 cycles -> irwrite=pcwrite=0 until the ready cycle.
